// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bundle: ID instruction fields, EX/MEM status in,
// PC / pipeline-register controls, forward selects and counters out.
interface hazard_scoreboard_if #(
    parameter int NSTAGE = 3,
    parameter int REG_AW = 5,
    parameter int SW     = $clog2(NSTAGE + 1)
);
    logic                    id_valid_i;
    logic [REG_AW-1:0]       id_rs1_i;
    logic [REG_AW-1:0]       id_rs2_i;
    logic                    id_use_rs1_i;
    logic                    id_use_rs2_i;
    logic [REG_AW-1:0]       id_rd_i;
    logic                    id_we_i;
    logic                    id_is_load_i;
    logic                    ex_redirect_i;
    logic                    dmem_req_i;
    logic                    dmem_ack_i;
    logic                    pc_hold_o;
    logic [2*(NSTAGE+1)-1:0] pipe_ctrl_o;
    logic [SW-1:0]           fwd_rs1_o;
    logic [SW-1:0]           fwd_rs2_o;
    logic [31:0]             stall_cnt_o;
    logic [31:0]             flush_cnt_o;
    logic                    timeout_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        output id_rd_i, id_we_i, id_is_load_i, ex_redirect_i,
        output dmem_req_i, dmem_ack_i,
        input  pc_hold_o, pipe_ctrl_o, fwd_rs1_o, fwd_rs2_o,
        input  stall_cnt_o, flush_cnt_o, timeout_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
        input  id_rd_i, id_we_i, id_is_load_i, ex_redirect_i,
        input  dmem_req_i, dmem_ack_i,
        output pc_hold_o, pipe_ctrl_o, fwd_rs1_o, fwd_rs2_o,
        output stall_cnt_o, flush_cnt_o, timeout_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard controller: tracks in-flight writers per stage
// and derives stall/flush/freeze controls, forward selects and counters.
module hazard_scoreboard #(
    parameter int NSTAGE   = 3,
    parameter int REG_AW   = 5,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 15,
    parameter int SW       = $clog2(NSTAGE + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hazard_scoreboard_if.slave bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int CW = 2 * (NSTAGE + 1);

    logic [NSTAGE:1]   wr_q, wr_d;
    logic [NSTAGE:1]   ld_q, ld_d;
    logic [REG_AW-1:0] rd_q [NSTAGE:1];
    logic [REG_AW-1:0] rd_d [NSTAGE:1];
    logic [31:0]       stall_q, stall_d;
    logic [31:0]       flush_q, flush_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic [SW-1:0] win1, win2;
    logic          hit1, hit2;
    logic          young1, young2;
    logic          haz1, haz2;
    logic          hazard_ld, freeze, insert;
    logic          pc_hold;
    logic [CW-1:0] ctrl;

    // Scan oldest to youngest so the youngest matching slot is left standing.
    always_comb begin
        win1   = '0;
        win2   = '0;
        hit1   = 1'b0;
        hit2   = 1'b0;
        young1 = 1'b0;
        young2 = 1'b0;
        for (int s = NSTAGE; s >= 1; s--) begin
            if (bus.id_use_rs1_i && wr_q[s] && rd_q[s] == bus.id_rs1_i) begin
                hit1   = 1'b1;
                win1   = SW'(s);
                young1 = ld_q[s] && (s <= LOAD_LAT);
            end
            if (bus.id_use_rs2_i && wr_q[s] && rd_q[s] == bus.id_rs2_i) begin
                hit2   = 1'b1;
                win2   = SW'(s);
                young2 = ld_q[s] && (s <= LOAD_LAT);
            end
        end
    end

    assign haz1      = (FWD_EN != 0) ? (hit1 && young1) : hit1;
    assign haz2      = (FWD_EN != 0) ? (hit2 && young2) : hit2;
    assign hazard_ld = bus.id_valid_i && (haz1 || haz2);
    assign freeze    = bus.dmem_req_i && !bus.dmem_ack_i;
    assign insert    = bus.id_valid_i && !bus.ex_redirect_i && !hazard_ld;

    always_comb begin
        pc_hold = 1'b0;
        ctrl    = '0;
        if (rst_i) begin
            ctrl = {CW{1'b1}};
        end else if (freeze) begin
            pc_hold = 1'b1;
            ctrl    = {(NSTAGE + 1){2'b01}};
        end else if (bus.ex_redirect_i) begin
            ctrl[3:0] = 4'b1111;
        end else if (hazard_ld) begin
            pc_hold   = 1'b1;
            ctrl[3:0] = 4'b1101;
        end
    end

    always_comb begin
        wr_d      = wr_q;
        ld_d      = ld_q;
        rd_d      = rd_q;
        stall_d   = stall_q;
        flush_d   = flush_q;
        wait_d    = '0;
        timeout_d = timeout_q;
        if (freeze) begin
            wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
        end else begin
            for (int s = NSTAGE; s >= 2; s--) begin
                wr_d[s] = wr_q[s-1];
                ld_d[s] = ld_q[s-1];
                rd_d[s] = rd_q[s-1];
            end
            wr_d[1] = insert && bus.id_we_i && (bus.id_rd_i != '0);
            ld_d[1] = insert && bus.id_is_load_i;
            rd_d[1] = bus.id_rd_i;
            if (bus.ex_redirect_i) begin
                flush_d = flush_q + 32'd1;
            end else if (hazard_ld) begin
                stall_d = stall_q + 32'd1;
            end
        end
        if (wait_d == WW'(MAX_WAIT)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q      <= '0;
            ld_q      <= '0;
            for (int s = 1; s <= NSTAGE; s++) begin
                rd_q[s] <= '0;
            end
            stall_q   <= '0;
            flush_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            ld_q      <= ld_d;
            rd_q      <= rd_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_hold_o   = pc_hold;
    assign bus.pipe_ctrl_o = ctrl;
    assign bus.fwd_rs1_o   = (!rst_i && FWD_EN != 0 && hit1 && !young1) ? win1 : '0;
    assign bus.fwd_rs2_o   = (!rst_i && FWD_EN != 0 && hit2 && !young2) ? win2 : '0;
    assign bus.stall_cnt_o = stall_q;
    assign bus.flush_cnt_o = flush_q;
    assign bus.timeout_o   = timeout_q;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard controller for the RV32I core, generalising the fixed load-use/branch hazard unit to any number of post-decode stages. It keeps an internal scoreboard of in-flight register writers that shifts in lockstep with the pipeline. From that scoreboard it produces per-pipeline-register advance/hold/flush controls, operand forwarding selects, data-memory wait freezes, and stall/flush performance counters. It sits beside the decode stage and drives the PC and every pipeline register enable/clear.

## Interface
- NSTAGE, 3: number of post-ID pipeline registers that can hold a writer; slot 1 = ID/EX … slot NSTAGE = last (WB)
- REG_AW, 5: register index width
- FWD_EN, 1: 1 = forwarding mode; 0 = stall until writer leaves slot NSTAGE
- LOAD_LAT, 1: load data is forwardable only from slots > LOAD_LAT
- MAX_WAIT, 15: memory-wait cycles tolerated before timeout
- SW, $clog2(NSTAGE+1): forward-select width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  valid instruction in IF/ID
- id_rs1_i, id_rs2_i  in  REG_AW  source registers
- id_use_rs1_i, id_use_rs2_i  in  1  source actually read
- id_rd_i  in  REG_AW  destination
- id_we_i  in  1  instruction writes rd
- id_is_load_i  in  1  instruction is a load
- ex_redirect_i  in  1  taken branch/jump resolved in EX
- dmem_req_i, dmem_ack_i  in  1  MEM-stage request / completion
- pc_hold_o  out  1  1 = PC holds
- pipe_ctrl_o  out  2*(NSTAGE+1)  2 bits per pipeline register k (k=0 IF/ID … k=NSTAGE), LSB pair = k0; 00 advance, 01 hold, 11 flush (bubble); 10 never driven
- fwd_rs1_o, fwd_rs2_o  out  SW  0 = register file, s = forward from slot s
- stall_cnt_o, flush_cnt_o  out  32  load-use bubbles / redirects since reset, wrap at 2^32
- timeout_o  out  1  sticky memory-wait timeout

## Operation
- Scoreboard slot s (1..NSTAGE): {wr, rd, ld}; wr only if we and rd != 0.
- Match(rsX, s): use_rsX, slot s wr, rd == rsX; youngest (lowest s) matching slot wins.
- hazard_ld: id_valid_i and a winning match with FWD_EN=1, ld=1, s <= LOAD_LAT; or with FWD_EN=0, any match in any slot.
- Forward select: FWD_EN=1 and the winning match is not hazard_ld → s; otherwise 0. With FWD_EN=0 always 0.
- freeze = dmem_req_i and not dmem_ack_i.
- Priority, evaluated every cycle:
  - freeze: pc_hold_o=1, all pairs 01, scoreboard and counters other than the wait counter unchanged.
  - else ex_redirect_i: pc_hold_o=0, k0 and k1 = 11, rest 00, flush_cnt_o+1; hazard_ld ignored.
  - else hazard_ld: pc_hold_o=1, k0=01, k1=11, rest 00, stall_cnt_o+1.
  - else all 00, pc_hold_o=0.
- Scoreboard shift when not frozen: slot[s+1] <= slot[s]. slot[1] <= ID instruction if id_valid_i and no redirect and no hazard_ld; otherwise a bubble (wr=0). Slot NSTAGE shifts out.
- Wait counter: increments each freeze cycle and clears when not frozen. Reaching MAX_WAIT sets timeout_o, which clears only on rst_i.

## Timing
- All control and forward outputs are combinational from inputs plus scoreboard state, consumed at the next rising edge.
- Scoreboard, counters and timeout_o are registered; updates are visible the cycle after the triggering edge.
- While rst_i=1: pc_hold_o=0, all pairs 11, fwd 0. The edge with rst_i=1 clears the scoreboard, counters, wait counter and timeout_o.
- Reset asserted mid-stall or mid-freeze aborts it; no carried state survives.
- A redirect during freeze is held off: EX is frozen, so ex_redirect_i stays high and takes effect on the first unfrozen cycle.
- Load-use bubble count = LOAD_LAT - s + 1 cycles for a writer first seen at slot s (FWD_EN=1). FWD_EN=0 stalls until the writer leaves slot NSTAGE.

## Test plan
- NSTAGE=3, LOAD_LAT=1: issue lw x5, next add x6,x5,x1 → 1 cycle with pc_hold_o=1, k0=01, k1=11; then fwd_rs1_o=2; stall_cnt_o=1.
- add x5 then sub uses x5 (FWD_EN=1) → no stall, fwd_rs1_o=1; next cycle with a new reader fwd=2, then 3, then 0.
- FWD_EN=0, add x5 then reader of x5 → 3 stall cycles, then advance with fwd 0.
- Writer rd=x0 followed by reader of x0; also use_rs2=0 with rs2 matching → no stall, fwd 0.
- lw x5 + dependent reader with ex_redirect_i=1 in the same cycle → k0=k1=11, pc_hold_o=0, flush_cnt_o=1, stall_cnt_o=0.
- dmem_req_i=1, dmem_ack_i=0 for 3 cycles → all pairs 01, pc_hold_o=1, scoreboard unchanged, timeout_o=0. Hold it for 15 cycles (MAX_WAIT=15) → timeout_o=1 and stays 1 until rst_i.
